// File: rtl/load_store_unit.sv
// load_store_unit
//
// Purpose:
//   Bridges the execute stage to a single-ported data memory. A request is
//   accepted in IDLE, checked for a legal funct3 and natural alignment, and
//   then either performed on the memory port (ACCESS) or answered straight
//   away with a fault (RESP). Store data is replicated across byte lanes;
//   load data is shifted down from its lane and sign/zero extended.
//
// Ports:
//   clk, rst_n        single clock, asynchronous active-low reset
//   req_valid/ready   request handshake from the execute stage
//   req_we            1 = store, 0 = load
//   req_funct3        access size / signedness (RISC-V encoding)
//   req_addr          byte address
//   req_wdata         store data (rs2)
//   resp_valid        one-cycle response pulse
//   resp_rdata        extended load data, 0 for stores and faults
//   resp_misaligned   alignment fault
//   resp_error        illegal funct3 or ack timeout
//   mem_req/mem_we    memory strobe and write enable (ACCESS only)
//   mem_addr          word-aligned address
//   mem_wdata         lane-replicated store data
//   mem_be            byte-lane enables (ACCESS only)
//   mem_ack           memory completed the access
//   mem_rdata         read word, valid with mem_ack
module load_store_unit #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Last counter value spent in ACCESS before giving up on mem_ack.
  localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [7:0]  wait_cnt;
  logic        req_illegal;
  logic        req_unaligned;
  logic        req_ok;
  logic        ack_timeout;
  logic [3:0]  lane_be;
  logic [31:0] rdata_shifted;
  logic [31:0] load_data;

  // Classify the incoming request while it sits on the input port. Signed
  // byte/half/word are legal for both directions, the unsigned variants only
  // for loads. A half needs an even address and a word a multiple of four.
  always_comb begin
    req_illegal   = 1'b1;
    req_unaligned = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
      3'b100, 3'b101:         req_illegal = req_we;
      default:                req_illegal = 1'b1;
    endcase
    case (req_funct3[1:0])
      2'b01:   req_unaligned = req_addr[0];
      2'b10:   req_unaligned = |req_addr[1:0];
      default: req_unaligned = 1'b0;
    endcase
    req_ok = !req_illegal && !req_unaligned;
  end

  assign ack_timeout = (wait_cnt == WAIT_LAST);

  // Byte lanes, store replication and load extraction all work from the
  // latched request so the memory port stays stable for the whole access.
  always_comb begin
    case (lat_funct3[1:0])
      2'b00: begin
        lane_be   = 4'b0001 << lat_addr[1:0];
        mem_wdata = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        lane_be   = 4'b0011 << lat_addr[1:0];
        mem_wdata = {2{lat_wdata[15:0]}};
      end
      default: begin
        lane_be   = 4'b1111;
        mem_wdata = lat_wdata;
      end
    endcase
    rdata_shifted = mem_rdata >> {lat_addr[1:0], 3'b000};
    case (lat_funct3)
      3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_data = {24'h000000, rdata_shifted[7:0]};
      3'b101:  load_data = {16'h0000, rdata_shifted[15:0]};
      default: load_data = rdata_shifted;
    endcase
  end

  assign mem_addr = {lat_addr[31:2], 2'b00};

  // State register. Because the memory strobes decode from this register,
  // an asynchronous reset drops mem_req without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and Moore outputs. A faulty request skips ACCESS entirely;
  // RESP always lasts exactly one cycle.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_be     = 4'b0000;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          next_state = req_ok ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        mem_req = 1'b1;
        mem_we  = lat_we;
        mem_be  = lane_be;
        if (mem_ack || ack_timeout) begin
          next_state = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latch, wait counter and response registers. The response fields
  // are only written on the edge that enters RESP, so they hold their value
  // until the next response. An ack in the final allowed cycle still counts
  // as a successful access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we          <= 1'b0;
      lat_funct3      <= 3'b000;
      lat_addr        <= 32'h0;
      lat_wdata       <= 32'h0;
      wait_cnt        <= 8'h00;
      resp_rdata      <= 32'h0;
      resp_misaligned <= 1'b0;
      resp_error      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= 8'h00;
          if (req_valid) begin
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            if (!req_ok) begin
              resp_rdata      <= 32'h0;
              resp_error      <= req_illegal;
              resp_misaligned <= req_unaligned && !req_illegal;
            end
          end
        end
        ACCESS: begin
          wait_cnt <= wait_cnt + 8'h01;
          if (mem_ack) begin
            resp_rdata      <= lat_we ? 32'h0 : load_data;
            resp_error      <= 1'b0;
            resp_misaligned <= 1'b0;
          end else if (ack_timeout) begin
            resp_rdata      <= 32'h0;
            resp_error      <= 1'b1;
            resp_misaligned <= 1'b0;
          end
        end
        default: begin
          wait_cnt <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//
// Purpose:
//   Directed bench for load_store_unit. The stimulus process issues each
//   request, plays the memory (ack after a chosen number of wait states, or
//   never), checks the memory-side signals, and pushes the expected response
//   into a scoreboard queue. A separate monitor pops and compares whenever
//   resp_valid is seen, including the accept-to-response latency.
//
// Ports: none (top-level bench).
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_error;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        err;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  load_store_unit #(.ACK_TIMEOUT(15)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .resp_error      (resp_error),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_be          (mem_be),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising-edge counter used to measure accept-to-response latency.
  always @(posedge clk) begin
    cyc = cyc + 1;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest queued expectation,
  // and a pulse with nothing queued is itself a failure.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("[TB] FAIL unexpected_resp actual=1 expected=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("resp_rdata", resp_rdata, e.rdata);
        check_output("resp_misaligned", {31'b0, resp_misaligned}, {31'b0, e.mis});
        check_output("resp_error", {31'b0, resp_error}, {31'b0, e.err});
        check_output("resp_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
      end
    end
  end

  // Issue one request and act as the memory. waits < 0 means never ack.
  // exp_hi is the number of cycles mem_req must stay high.
  task automatic apply_stimulus(
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [31:0] mrd,
    input int          waits,
    input int          exp_hi,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_wdata,
    input logic [31:0] exp_rdata,
    input logic        exp_mis,
    input logic        exp_err,
    input int          exp_lat
  );
    exp_t e;
    int   hi;
    int   guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_output("req_ready", {31'b0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    e.rdata    = exp_rdata;
    e.mis      = exp_mis;
    e.err      = exp_err;
    e.acc_cyc  = cyc;
    e.lat      = exp_lat;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = 32'h5A5A5A5A;
    req_addr  = 32'hFFFFFFFF;
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      if (!mem_req) break;
      hi++;
      check_output("mem_addr", mem_addr, {addr[31:2], 2'b00});
      check_output("mem_be", {28'b0, mem_be}, {28'b0, exp_be});
      check_output("mem_we", {31'b0, mem_we}, {31'b0, we});
      check_output("mem_wdata", mem_wdata, exp_wdata);
      if (waits >= 0 && i == waits) begin
        mem_ack   = 1'b1;
        mem_rdata = mrd;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEADBEEF;
        break;
      end
      @(negedge clk);
    end
    check_output("mem_req_cycles", 32'(hi), 32'(exp_hi));
    check_output("mem_req_after", {31'b0, mem_req}, 32'h0);
    check_output("mem_be_after", {28'b0, mem_be}, 32'h0);
    guard = 0;
    while (sb.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL resp_timeout actual=none expected=resp_valid");
      sb.delete();
    end
  endtask

  // Safety net in case the DUT wedges the stimulus process.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'hDEADBEEF;
    @(negedge clk);
    @(negedge clk);
    check_output("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check_output("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check_output("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check_output("rst_mem_addr", mem_addr, 32'h0);
    check_output("rst_resp_rdata", resp_rdata, 32'h0);
    rst_n = 1'b1;

    // mem_ack while idle must not produce anything
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check_output("idle_ack_ready", {31'b0, req_ready}, 32'h1);

    // LB 0x103 -> lane 3, 0x80 sign-extended
    apply_stimulus(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 1, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0, 2);
    @(negedge clk);
    check_output("resp_hold", resp_rdata, 32'hFFFFFF80);
    // SH 0x202
    apply_stimulus(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'hDEADBEEF, 0, 1, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0, 1'b0, 2);
    // LW 0x101 misaligned
    apply_stimulus(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 1);
    // load funct3 011 illegal
    apply_stimulus(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 1);
    // illegal 110 at odd address: error wins over misalignment
    apply_stimulus(1'b0, 3'b110, 32'h3, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 1);
    // store with unsigned funct3 is illegal
    apply_stimulus(1'b1, 3'b100, 32'h0, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 1);
    // SH 0x1 misaligned
    apply_stimulus(1'b1, 3'b001, 32'h1, 32'h1234, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 1);
    // LHU 0x0 with no ack -> timeout after 15 ACCESS cycles
    apply_stimulus(1'b0, 3'b101, 32'h0, 32'h0, 32'h0, -1, 15, 4'b0011, 32'h0, 32'h0, 1'b0, 1'b1, 16);
    // LHU 0x2, one wait state
    apply_stimulus(1'b0, 3'b101, 32'h2, 32'h0, 32'h80FF1234, 1, 2, 4'b1100, 32'h0, 32'h000080FF, 1'b0, 1'b0, 3);
    // LH 0x2
    apply_stimulus(1'b0, 3'b001, 32'h2, 32'h0, 32'h80FF1234, 0, 1, 4'b1100, 32'h0, 32'hFFFF80FF, 1'b0, 1'b0, 2);
    // LBU 0x1
    apply_stimulus(1'b0, 3'b100, 32'h1, 32'h0, 32'h80FF1234, 0, 1, 4'b0010, 32'h0, 32'h00000012, 1'b0, 1'b0, 2);
    // LB 0x0 positive byte
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h80FF1234, 0, 1, 4'b0001, 32'h0, 32'h00000034, 1'b0, 1'b0, 2);
    // LW 0x4
    apply_stimulus(1'b0, 3'b010, 32'h4, 32'h0, 32'h80FF1234, 0, 1, 4'b1111, 32'h0, 32'h80FF1234, 1'b0, 1'b0, 2);
    // SB 0x3
    apply_stimulus(1'b1, 3'b000, 32'h3, 32'h12345678, 32'h0, 0, 1, 4'b1000, 32'h78787878, 32'h0, 1'b0, 1'b0, 2);
    // SW 0x2 misaligned
    apply_stimulus(1'b1, 3'b010, 32'h2, 32'h1, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 1);
    // three back-to-back SW with two wait states each
    apply_stimulus(1'b1, 3'b010, 32'h10, 32'h11112222, 32'h0, 2, 3, 4'b1111, 32'h11112222, 32'h0, 1'b0, 1'b0, 4);
    apply_stimulus(1'b1, 3'b010, 32'h14, 32'h33334444, 32'h0, 2, 3, 4'b1111, 32'h33334444, 32'h0, 1'b0, 1'b0, 4);
    apply_stimulus(1'b1, 3'b010, 32'h18, 32'h55556666, 32'h0, 2, 3, 4'b1111, 32'h55556666, 32'h0, 1'b0, 1'b0, 4);

    // reset in the middle of an access: strobe drops at once, no response
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h8;
    @(negedge clk);
    req_valid = 1'b0;
    check_output("pre_rst_mem_req", {31'b0, mem_req}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_rst_mem_req", {31'b0, mem_req}, 32'h0);
    check_output("async_rst_ready", {31'b0, req_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check_output("post_rst_ready", {31'b0, req_ready}, 32'h1);
    check_output("post_rst_rdata", resp_rdata, 32'h0);
    check_output("post_rst_mem_req", {31'b0, mem_req}, 32'h0);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 15, maximum cycles spent in ACCESS waiting for mem_ack before an error response (range 1..255).
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid  input  1  execute stage presents a memory operation.
REQ-005 Port: req_ready  output  1  unit can accept a request this cycle.
REQ-006 Port: req_we  input  1  1 = store, 0 = load.
REQ-007 Port: req_funct3  input  3  000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-008 Port: req_addr  input  32  byte address, driven from the ALU result.
REQ-009 Port: req_wdata  input  32  store data (rs2 value).
REQ-010 Port: resp_valid  output  1  one-cycle response pulse.
REQ-011 Port: resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-012 Port: resp_misaligned  output  1  response flags an address-alignment fault.
REQ-013 Port: resp_error  output  1  response flags an illegal funct3 or an ack timeout.
REQ-014 Port: mem_req, mem_we  output  1 each  memory strobe and write enable.
REQ-015 Port: mem_addr  output  32  word address, {req_addr[31:2], 2'b00}.
REQ-016 Port: mem_wdata  output  32  lane-replicated store data.
REQ-017 Port: mem_be  output  4  byte-lane enables.
REQ-018 Port: mem_ack  input  1  memory completed the access this cycle.
REQ-019 Port: mem_rdata  input  32  read word, valid when mem_ack = 1.

Function
REQ-020 FSM states: IDLE, ACCESS, RESP; req_ready = 1 only in IDLE.
REQ-021 IDLE transitions: on req_valid = 1, latch all req_* fields; a legal, aligned request goes to ACCESS; any other request goes directly to RESP with no memory access.
REQ-022 Legal funct3 values: loads use 000, 001, 010, 100, 101; stores use 000, 001, 010; every other value sets resp_error.
REQ-023 Alignment: half accesses need addr[0] = 0 and word accesses need addr[1:0] = 00; a violation sets resp_misaligned; an illegal funct3 takes priority (error = 1, misaligned = 0).
REQ-024 ACCESS outputs: mem_req = 1, with mem_we, mem_addr, mem_be and mem_wdata held stable from the latched request until the state is left.
REQ-025 Byte lanes: byte be = 0001 << addr[1:0]; half be = 0011 << addr[1:0]; word be = 1111.
REQ-026 Store data: mem_wdata = {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, wdata for word.
REQ-027 Load extraction: select mem_rdata >> (8*addr[1:0]); sign-extend for 000 and 001, zero-extend for 100 and 101.
REQ-028 Extracted load data is captured on the edge where mem_ack = 1 in ACCESS, and the state then moves to RESP.
REQ-029 Timeout: a cycle counter clears on entry to ACCESS; when ACK_TIMEOUT cycles pass without mem_ack, go to RESP with resp_error = 1, and mem_req drops in RESP.
REQ-030 RESP: resp_valid = 1 for exactly one cycle, then unconditional return to IDLE; resp_* fields are held until the next response.
REQ-031 Latency with zero wait states: accept edge to RESP is 2 cycles; each extra wait cycle adds 1; a rejected request takes 1 cycle.
REQ-032 mem_ack is ignored outside ACCESS.
REQ-033 Back-to-back requests: a new request is accepted in the IDLE cycle that follows RESP; there is no same-cycle accept during RESP.
REQ-034 mem_req, mem_we and mem_be are 0 in every state except ACCESS.

Reset
REQ-035 rst_n = 0 asynchronously forces IDLE and clears the counter, latched fields and all outputs to 0, except req_ready, which is 1 after reset.
REQ-036 Reset during ACCESS drops mem_req immediately, without waiting for a clock, and produces no response.

Verification
REQ-037 LB at addr 0x103 with mem_rdata 0x80FF_1234 and ack in the first ACCESS cycle -> mem_addr 0x100, be 1000, resp_rdata 0xFFFF_FF80, resp_valid 2 cycles after accept.
REQ-038 SH at addr 0x202 with wdata 0x0000_ABCD -> mem_we 1, be 1100, mem_wdata 0xABCD_ABCD, resp_rdata 0.
REQ-039 LW at addr 0x101 -> no mem_req, resp_misaligned 1, resp_valid 1 cycle after accept; req_funct3 = 011 -> resp_error 1.
REQ-040 LHU at 0x0 with mem_ack withheld and ACK_TIMEOUT = 15 -> mem_req high for 15 cycles, then resp_error 1 and mem_req 0.
REQ-041 rst_n pulled low mid-ACCESS -> mem_req 0 in the same cycle, no resp_valid, req_ready 1 after release.
REQ-042 Three back-to-back SW requests with 2 wait states each -> three responses, each 4 cycles after its accept, with fields stable while mem_req is high.
